// File: rtl/rate_limiter_pkg.sv
// Shared types and constants for the multi-channel clamp + slew rate limiter.
package rate_limiter_pkg;

    // Width of the saturating flagged-sample counter.
    localparam int SAT_W = 16;

    // Config fields are carried at a fixed width that covers any sample width,
    // so the struct does not depend on the instantiating module's parameters.
    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'd0,
        MODE_CLAMP    = 2'd1,
        MODE_SLEW     = 2'd2,
        MODE_SLEW_ALT = 2'd3
    } mode_e;

    // Active configuration shared by every channel.
    typedef struct packed {
        logic signed [CFG_W-1:0] hi;
        logic signed [CFG_W-1:0] lo;
        logic        [CFG_W-1:0] step;
        mode_e                   mode;
    } cfg_t;

    // The clamp stage is active in every mode except bypass.
    function automatic logic mode_clamps(mode_e m);
        return m != MODE_BYPASS;
    endfunction

    // The slew stage is active in both slew encodings.
    function automatic logic mode_slews(mode_e m);
        return (m == MODE_SLEW) || (m == MODE_SLEW_ALT);
    endfunction

endpackage

// File: rtl/rate_limiter_lane.sv
// One channel of the rate limiter: clamp stage, then slew stage.
// The stage-2 output register doubles as the per-channel prev register,
// since prev is defined as the last valid output value.
module rate_limiter_lane
    import rate_limiter_pkg::*;
#(
    parameter int BITS = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  cfg_t                   cfg,
    input  logic                   s1_valid,
    input  logic signed [BITS-1:0] x,
    input  logic                   s2_valid,
    output logic signed [BITS-1:0] y,
    output logic                   clip_flag,
    output logic                   slew_flag,
    output logic                   flag_next
);

    logic signed [BITS-1:0]  c_q, c_d;
    logic                    clip1_q, clip1_d;
    logic signed [BITS-1:0]  prev_q, prev_d;
    logic                    clip2_q, clip2_d;
    logic                    slew_q, slew_d;
    logic signed [BITS:0]    diff;
    logic signed [CFG_W-1:0] step_s;

    // Difference to the previous output; BITS+1 bits cannot overflow.
    assign diff   = (BITS+1)'(c_q) - (BITS+1)'(prev_q);
    assign step_s = $signed(cfg.step);

    // Stage 1: signed clamp against the bounds active this cycle.
    always_comb begin
        c_d     = c_q;
        clip1_d = clip1_q;
        if (s1_valid) begin
            c_d     = x;
            clip1_d = 1'b0;
            if (mode_clamps(cfg.mode)) begin
                if (CFG_W'(x) > cfg.hi) begin
                    c_d     = BITS'(cfg.hi);
                    clip1_d = 1'b1;
                end else if (CFG_W'(x) < cfg.lo) begin
                    c_d     = BITS'(cfg.lo);
                    clip1_d = 1'b1;
                end
            end
        end
    end

    // Stage 2: limit the change from prev to at most step per valid sample.
    always_comb begin
        prev_d  = prev_q;
        clip2_d = 1'b0;
        slew_d  = 1'b0;
        if (s2_valid) begin
            prev_d  = c_q;
            clip2_d = clip1_q;
            if (mode_slews(cfg.mode)) begin
                if (CFG_W'(diff) > step_s) begin
                    prev_d = BITS'(CFG_W'(prev_q) + step_s);
                    slew_d = 1'b1;
                end else if (CFG_W'(diff) < -step_s) begin
                    prev_d = BITS'(CFG_W'(prev_q) - step_s);
                    slew_d = 1'b1;
                end
            end
        end
    end

    // Pipeline registers; reset clears data, flags and prev.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q     <= '0;
            clip1_q <= 1'b0;
            prev_q  <= '0;
            clip2_q <= 1'b0;
            slew_q  <= 1'b0;
        end else begin
            c_q     <= c_d;
            clip1_q <= clip1_d;
            prev_q  <= prev_d;
            clip2_q <= clip2_d;
            slew_q  <= slew_d;
        end
    end

    assign y         = prev_q;
    assign clip_flag = clip2_q;
    assign slew_flag = slew_q;
    assign flag_next = clip2_d | slew_d;

endmodule

// File: rtl/rate_limiter.sv
// Multi-channel clamp + slew rate limiter, 2-stage pipeline, no backpressure.
// Handshake: in_valid qualifies in_data for one cycle and is always accepted;
// out_valid qualifies out_data exactly two cycles later. There is no ready.
module rate_limiter
    import rate_limiter_pkg::*;
#(
    parameter int BITS      = 11,
    parameter int CHANNELS  = 4,
    parameter int LIMIT     = 1000,
    parameter int STEP_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [CHANNELS*BITS-1:0]   in_data,
    input  logic                       cfg_load,
    input  logic signed [BITS-1:0]     cfg_hi,
    input  logic signed [BITS-1:0]     cfg_lo,
    input  logic [STEP_BITS-1:0]       cfg_step,
    input  logic [1:0]                 cfg_mode,
    output logic                       out_valid,
    output logic [CHANNELS*BITS-1:0]   out_data,
    output logic [CHANNELS-1:0]        clip_flags,
    output logic [CHANNELS-1:0]        slew_flags,
    output logic [SAT_W-1:0]           sat_count,
    output logic                       cfg_err
);

    localparam cfg_t CFG_RESET = '{
        hi:   CFG_W'(LIMIT),
        lo:   CFG_W'(-LIMIT),
        step: CFG_W'({STEP_BITS{1'b1}}),
        mode: MODE_CLAMP
    };

    cfg_t              cfg_q, cfg_d;
    logic              cfg_err_q, cfg_err_d;
    logic              v1_q, v1_d;
    logic              out_valid_q, out_valid_d;
    logic [SAT_W-1:0]  sat_count_q, sat_count_d;
    logic [CHANNELS-1:0] flag_next;

    // Accept a config only when its bounds are ordered; otherwise latch the error.
    always_comb begin
        cfg_d     = cfg_q;
        cfg_err_d = cfg_err_q;
        if (cfg_load) begin
            if (cfg_lo <= cfg_hi) begin
                cfg_d.hi   = CFG_W'(cfg_hi);
                cfg_d.lo   = CFG_W'(cfg_lo);
                cfg_d.step = CFG_W'(cfg_step);
                cfg_d.mode = mode_e'(cfg_mode);
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // Valid pipeline and saturating count of flagged outputs.
    always_comb begin
        v1_d        = in_valid;
        out_valid_d = v1_q;
        sat_count_d = sat_count_q;
        if ((|flag_next) && (sat_count_q != {SAT_W{1'b1}})) begin
            sat_count_d = sat_count_q + 1'b1;
        end
    end

    // Control state; reset wins over in_valid and cfg_load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q       <= CFG_RESET;
            cfg_err_q   <= 1'b0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sat_count_q <= '0;
        end else begin
            cfg_q       <= cfg_d;
            cfg_err_q   <= cfg_err_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            sat_count_q <= sat_count_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        rate_limiter_lane #(
            .BITS (BITS)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .cfg       (cfg_q),
            .s1_valid  (in_valid),
            .x         (in_data[k*BITS +: BITS]),
            .s2_valid  (v1_q),
            .y         (out_data[k*BITS +: BITS]),
            .clip_flag (clip_flags[k]),
            .slew_flag (slew_flags[k]),
            .flag_next (flag_next[k])
        );
    end

    assign out_valid = out_valid_q;
    assign sat_count = sat_count_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_rate_limiter.sv
// Bench for rate_limiter: table vectors, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_rate_limiter;

    localparam int BITS      = 12;
    localparam int CH        = 4;
    localparam int LIMIT     = 1000;
    localparam int STEP_BITS = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [CH*BITS-1:0]     in_data = '0;
    logic                   cfg_load = 1'b0;
    logic signed [BITS-1:0] cfg_hi = '0;
    logic signed [BITS-1:0] cfg_lo = '0;
    logic [STEP_BITS-1:0]   cfg_step = '0;
    logic [1:0]             cfg_mode = '0;
    logic                   out_valid;
    logic [CH*BITS-1:0]     out_data;
    logic [CH-1:0]          clip_flags;
    logic [CH-1:0]          slew_flags;
    logic [15:0]            sat_count;
    logic                   cfg_err;

    rate_limiter #(
        .BITS (BITS), .CHANNELS (CH), .LIMIT (LIMIT), .STEP_BITS (STEP_BITS)
    ) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
        .cfg_load (cfg_load), .cfg_hi (cfg_hi), .cfg_lo (cfg_lo),
        .cfg_step (cfg_step), .cfg_mode (cfg_mode),
        .out_valid (out_valid), .out_data (out_data), .clip_flags (clip_flags),
        .slew_flags (slew_flags), .sat_count (sat_count), .cfg_err (cfg_err)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Behavioural model: config, prev per channel, one sample between stages.
    int            m_hi, m_lo, m_step, m_mode, m_sat;
    bit            m_err;
    int            m_prev[CH];
    bit            s1_v;
    int            s1_c[CH];
    bit            s1_clip[CH];
    bit            e_v, e_rst;
    int            e_y[CH];
    logic [CH-1:0] e_clip, e_slew;
    int            x_in[CH];

    task automatic model_reset();
        m_hi = LIMIT; m_lo = -LIMIT; m_step = 255; m_mode = 1;
        m_sat = 0; m_err = 1'b0; s1_v = 1'b0;
        e_v = 1'b0; e_rst = 1'b1; e_clip = '0; e_slew = '0;
        for (int k = 0; k < CH; k++) begin
            m_prev[k] = 0; e_y[k] = 0; s1_c[k] = 0; s1_clip[k] = 1'b0;
        end
    endtask

    // Expected state after the coming clock edge, from the pre-edge state.
    task automatic model_step(input bit v, input bit r);
        int c, y, d;
        if (r) begin
            model_reset();
            return;
        end
        e_rst  = 1'b0;
        e_v    = s1_v;
        e_clip = '0;
        e_slew = '0;
        if (s1_v) begin
            for (int k = 0; k < CH; k++) begin
                c = s1_c[k];
                y = c;
                d = c - m_prev[k];
                if (m_mode >= 2) begin
                    if (d > m_step) begin
                        y = m_prev[k] + m_step; e_slew[k] = 1'b1;
                    end else if (d < -m_step) begin
                        y = m_prev[k] - m_step; e_slew[k] = 1'b1;
                    end
                end
                e_y[k]    = y;
                m_prev[k] = y;
                e_clip[k] = s1_clip[k];
            end
            if (((e_clip | e_slew) != '0) && (m_sat < 65535)) m_sat++;
        end
        s1_v = v;
        if (v) begin
            for (int k = 0; k < CH; k++) begin
                c = x_in[k];
                s1_clip[k] = 1'b0;
                if (m_mode != 0) begin
                    if (c > m_hi) begin c = m_hi; s1_clip[k] = 1'b1; end
                    else if (c < m_lo) begin c = m_lo; s1_clip[k] = 1'b1; end
                end
                s1_c[k] = c;
            end
        end
        if (cfg_load) begin
            if (int'(cfg_lo) <= int'(cfg_hi)) begin
                m_hi = int'(cfg_hi); m_lo = int'(cfg_lo);
                m_step = int'(cfg_step); m_mode = int'(cfg_mode);
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid", out_valid, e_v);
        check("cfg_err", cfg_err, m_err);
        check("sat_count", sat_count, m_sat);
        check("clip_flags", clip_flags, e_clip);
        check("slew_flags", slew_flags, e_slew);
        if (e_v || e_rst) begin
            for (int k = 0; k < CH; k++)
                check($sformatf("out_data[%0d]", k), $signed(out_data[k*BITS +: BITS]), e_y[k]);
        end
    endtask

    // Driver: present inputs for one cycle, advance the model, sample after the edge.
    task automatic cycle(input bit v, input bit r);
        rst      = r;
        in_valid = v;
        for (int k = 0; k < CH; k++) in_data[k*BITS +: BITS] = BITS'(x_in[k]);
        model_step(v, r);
        @(posedge clk);
        #1;
        compare_all();
        cfg_load = 1'b0;
    endtask

    task automatic set_cfg(input int hi, input int lo, input int step, input int mode);
        cfg_hi   = BITS'(hi);
        cfg_lo   = BITS'(lo);
        cfg_step = STEP_BITS'(step);
        cfg_mode = 2'(mode);
        cfg_load = 1'b1;
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        x_in[0] = a; x_in[1] = b; x_in[2] = c; x_in[3] = d;
    endtask

    // Vector table: one input vector and the output it must produce.
    typedef struct {
        logic [CH-1:0][15:0] x;
        logic [CH-1:0][15:0] y;
        logic [CH-1:0]       clip;
        logic [CH-1:0]       slew;
    } vec_t;

    vec_t tbl[8];

    task automatic set_vec(input int i, input int x0, input int x1, input int x2, input int x3,
                           input int y0, input int y1, input int y2, input int y3,
                           input logic [CH-1:0] clip, input logic [CH-1:0] slew);
        tbl[i].x[0] = 16'(x0); tbl[i].x[1] = 16'(x1); tbl[i].x[2] = 16'(x2); tbl[i].x[3] = 16'(x3);
        tbl[i].y[0] = 16'(y0); tbl[i].y[1] = 16'(y1); tbl[i].y[2] = 16'(y2); tbl[i].y[3] = 16'(y3);
        tbl[i].clip = clip;
        tbl[i].slew = slew;
    endtask

    // Apply table entries a..b back to back; entry j emerges after drive j+1.
    task automatic run_table(input int a, input int b);
        int j;
        for (int i = a; i <= b + 1; i++) begin
            if (i <= b) begin
                for (int k = 0; k < CH; k++) x_in[k] = int'($signed(tbl[i].x[k]));
                cycle(1'b1, 1'b0);
            end else begin
                cycle(1'b0, 1'b0);
            end
            if (i > a) begin
                j = i - 1;
                check($sformatf("tbl%0d out_valid", j), out_valid, 1);
                check($sformatf("tbl%0d clip", j), clip_flags, tbl[j].clip);
                check($sformatf("tbl%0d slew", j), slew_flags, tbl[j].slew);
                for (int k = 0; k < CH; k++)
                    check($sformatf("tbl%0d data%0d", j, k), $signed(out_data[k*BITS +: BITS]),
                          int'($signed(tbl[j].y[k])));
            end
        end
    endtask

    initial begin
        int a, b, t;

        // Default-config clamp vector, then a ch0 slew ramp with step 100.
        set_vec(0, 1500, -1500, 999, -1000, 1000, -1000, 999, -1000, 4'b0011, 4'b0000);
        set_vec(1,   0, 0, 0, 0,   0, 0, 0, 0, 4'b0000, 4'b0000);
        set_vec(2, 500, 0, 0, 0, 100, 0, 0, 0, 4'b0000, 4'b0001);
        set_vec(3, 500, 0, 0, 0, 200, 0, 0, 0, 4'b0000, 4'b0001);
        set_vec(4, 500, 0, 0, 0, 300, 0, 0, 0, 4'b0000, 4'b0001);
        set_vec(5, 500, 0, 0, 0, 400, 0, 0, 0, 4'b0000, 4'b0001);
        set_vec(6, 500, 0, 0, 0, 500, 0, 0, 0, 4'b0000, 4'b0000);
        set_vec(7, 500, 0, 0, 0, 500, 0, 0, 0, 4'b0000, 4'b0000);

        // Reset state.
        model_reset();
        set_x(0, 0, 0, 0);
        repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Clamp under reset defaults.
        run_table(0, 0);

        // Slew ramp from a freshly reset prev.
        cycle(1'b0, 1'b1);
        set_cfg(1000, -1000, 100, 2);
        cycle(1'b0, 1'b0);
        run_table(1, 7);

        // Rejected config keeps the previous bounds.
        set_cfg(1000, -1000, 255, 1);
        cycle(1'b0, 1'b0);
        set_cfg(-10, 10, 5, 0);
        cycle(1'b0, 1'b0);
        check("bad_cfg cfg_err", cfg_err, 1);
        set_x(1500, -1500, 5, -5);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("bad_cfg hi kept", $signed(out_data[0 +: BITS]), 1000);
        check("bad_cfg lo kept", $signed(out_data[BITS +: BITS]), -1000);

        // Config load in the same cycle as a sample: that sample uses the old bounds.
        set_cfg(200, -1000, 255, 1);
        set_x(500, 0, 0, 0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("same_cycle old hi", $signed(out_data[0 +: BITS]), 500);
        cycle(1'b0, 1'b0);
        check("next new hi", $signed(out_data[0 +: BITS]), 200);
        check("next new hi clip", clip_flags, 4'b0001);

        // Reset with samples in flight discards them and clears prev.
        set_cfg(1000, -1000, 100, 2);
        cycle(1'b0, 1'b0);
        set_x(700, 700, 700, 700);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            check("flushed out_valid", out_valid, 0);
        end
        set_cfg(1000, -1000, 100, 2);
        cycle(1'b0, 1'b0);
        set_x(300, 0, 0, 0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("after rst slew from 0", $signed(out_data[0 +: BITS]), 100);

        // Saturation of the flagged-sample counter.
        set_cfg(1000, -1000, 255, 1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        force dut.sat_count_q = 16'hFFFE;
        m_sat = 65534;
        cycle(1'b0, 1'b0);
        release dut.sat_count_q;
        set_x(1500, 0, 0, 0);
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("sat_count saturated", sat_count, 32'h0000FFFF);
        cycle(1'b0, 1'b0);
        check("sat_count holds", sat_count, 32'h0000FFFF);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) begin
                a = int'($urandom_range(4094)) - 2047;
                b = int'($urandom_range(4094)) - 2047;
                if ($urandom_range(9) != 0 && a < b) begin
                    t = a; a = b; b = t;
                end
                set_cfg(a, b, ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255)),
                        int'($urandom_range(3)));
            end
            for (int k = 0; k < CH; k++) x_in[k] = int'($urandom_range(4094)) - 2047;
            cycle(($urandom_range(9) < 7), ($urandom_range(99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
